exmem_stage: RTL and testbench
==============================

# exmem_stage

EX→MEM pipeline stage sitting directly downstream of the execute ALU. It registers the ALU result and control bundle for the memory stage and resolves branches and jumps from the ALU flag. On a taken transfer it issues a one-cycle redirect to fetch and squashes the wrong-path instructions still in flight. A misaligned target is trapped: the stage halts intake until the trap is cleared.

## Interface
Parameters:
- WRONG_PATH, 2, number of younger instructions discarded after a taken redirect (1..7).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX bundle valid
- in_ready  out  1  stage accepts bundle this cycle
- alu_result  in  32  ALU output (rs1+imm for JALR, address for load/store)
- alu_flag  in  1  branch condition from ALU
- pc  in  32  instruction PC
- imm  in  32  sign-extended immediate
- is_branch / is_jal / is_jalr  in  1 each  control-flow class, at most one high
- rs2_data  in  32  store data
- rd  in  5  destination register
- reg_write / mem_read / mem_write  in  1 each  control
- mem_funct3  in  3  access size/sign
- out_valid  out  1  MEM bundle valid
- out_ready  in  1  MEM accepts
- out_result  out  32  writeback/address value
- out_store_data  out  32
- out_rd  out  5
- out_reg_write / out_mem_read / out_mem_write  out  1 each
- out_funct3  out  3
- out_exc  out  1  instruction-address-misaligned trap marker
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  32  fetch target
- trap_clear  in  1  leaves HALT

## Operation
- Accept = in_valid && in_ready. in_ready = (state != HALT) && (!out_valid || out_ready).
- taken = (is_branch && alu_flag) || is_jal || is_jalr.
- target: branch/JAL = pc + imm (mod 2^32); JALR = alu_result & ~32'h1.
- result: JAL/JALR → pc + 4; otherwise alu_result.
- misaligned = taken && target[1:0] != 0.
- FSM (state, squash_cnt[2:0]):
  - RUN: accept with taken && !misaligned → forward bundle, redirect pulse, go SQUASH, cnt = WRONG_PATH. Accept with misaligned → forward bundle with out_exc=1, reg_write/mem_write forced 0, no redirect, go HALT. Any other accept is forwarded unchanged.
  - SQUASH: each accept is discarded (out_valid not set by it, no redirect even if it is a taken transfer), cnt decrements; an accept while cnt==1 returns to RUN.
  - HALT: no intake; output register drains normally; trap_clear → RUN.
- Output register holds while out_valid && !out_ready; a discarded accept never overwrites pending output.

## Timing
- Latency 1: accept at edge N → out_* and out_valid visible after N, until MEM handshake.
- redirect_valid high exactly the cycle after the accepting edge; redirect_pc valid only then, otherwise 0.
- Reset values: out_valid 0, all out_* 0, redirect_valid 0, redirect_pc 0, state RUN, cnt 0; in_ready is 1 immediately after reset.
- Full stall with pending taken instruction: redirect still fires once, on acceptance only.
- trap_clear in RUN/SQUASH ignored. rst mid-SQUASH or mid-HALT → RUN, pending output dropped.
- out_valid && out_ready with a new accept on the same edge: new bundle replaces old, no bubble.

## Structure
- Shared package: state encoding (RUN, SQUASH, HALT), branch_type codes shared with the ALU, funct3 size codes, PC step constant 4.
- Optional sub-module exmem_target: combinational target/result/misaligned computation; FSM and registers stay in exmem_stage.

## Test plan
- Straight ALU ops, out_ready=1: alu_result 0x1234 rd=5 → out_result 0x1234 one cycle later, no redirect, back-to-back throughput 1/cycle.
- BEQ at pc 0x100, imm 0x20, alu_flag=1 → redirect_valid pulse, redirect_pc 0x120; next 2 accepted bundles dropped, third forwarded.
- JALR, alu_result 0x2003, pc 0x40 → redirect_pc 0x2002 → misaligned: out_exc=1, no redirect, in_ready=0 until trap_clear, then resumes.
- JAL pc 0x80 imm 0x10 → out_result 0x84, redirect_pc 0x90.
- out_ready=0 for 3 cycles with bundle pending → out_* stable, in_ready=0, no new accept lost.
- rst asserted mid-SQUASH (cnt=1) → out_valid 0, next taken branch after release redirects normally.

Source files
------------

// File: rtl/exmem_pkg.sv
// Shared EX/MEM definitions: FSM states, control-flow classes,
// access size codes and the sequential PC step.
package exmem_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BT_NONE   = 2'd0,
    BT_BRANCH = 2'd1,
    BT_JAL    = 2'd2,
    BT_JALR   = 2'd3
  } br_type_e;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic br_type_e br_type(
    input logic is_branch,
    input logic is_jal,
    input logic is_jalr
  );
    br_type_e bt;
    bt = BT_NONE;
    if (is_jalr)        bt = BT_JALR;
    else if (is_jal)    bt = BT_JAL;
    else if (is_branch) bt = BT_BRANCH;
    return bt;
  endfunction

endpackage

// File: rtl/exmem_target.sv
// Combinational control-flow resolution: taken flag, target,
// writeback result and target misalignment.
module exmem_target
  import exmem_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        alu_flag,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] result,
  output logic        misaligned
);

  br_type_e bt;

  always_comb begin
    bt     = br_type(is_branch, is_jal, is_jalr);
    taken  = 1'b0;
    target = pc + imm;
    result = alu_result;
    unique case (bt)
      BT_NONE: ;
      BT_BRANCH: taken = alu_flag;
      BT_JAL: begin
        taken  = 1'b1;
        result = pc + PC_STEP;
      end
      BT_JALR: begin
        taken  = 1'b1;
        target = alu_result & ~32'h1;
        result = pc + PC_STEP;
      end
    endcase
    misaligned = taken && (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/exmem_stage.sv
// EX->MEM pipeline register with branch/jump redirect,
// wrong-path squash and misaligned-target trap hold.
module exmem_stage
  import exmem_pkg::*;
#(
  parameter int WRONG_PATH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic        alu_flag,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic [2:0]  out_funct3,
  output logic        out_exc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        trap_clear
);

  localparam logic [2:0] WP_CNT = 3'(WRONG_PATH);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] res_q, res_d;
  logic [31:0] sd_q, sd_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        mr_q, mr_d;
  logic        mw_q, mw_d;
  logic [2:0]  f3_q, f3_d;
  logic        exc_q, exc_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;

  logic        taken;
  logic        misaligned;
  logic [31:0] target;
  logic [31:0] result;
  logic        accept;

  exmem_target u_target (
    .pc         (pc),
    .imm        (imm),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .is_branch  (is_branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .taken      (taken),
    .target     (target),
    .result     (result),
    .misaligned (misaligned)
  );

  assign in_ready = (state_q != ST_HALT) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q && !out_ready;
    res_d   = res_q;
    sd_d    = sd_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    f3_d    = f3_q;
    exc_d   = exc_q;
    rv_d    = 1'b0;
    rpc_d   = 32'h0;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          valid_d = 1'b1;
          res_d   = result;
          sd_d    = rs2_data;
          rd_d    = rd;
          rw_d    = reg_write;
          mr_d    = mem_read;
          mw_d    = mem_write;
          f3_d    = mem_funct3;
          exc_d   = 1'b0;
          if (misaligned) begin
            exc_d   = 1'b1;
            rw_d    = 1'b0;
            mw_d    = 1'b0;
            state_d = ST_HALT;
          end else if (taken) begin
            rv_d    = 1'b1;
            rpc_d   = target;
            cnt_d   = WP_CNT;
            state_d = ST_SQUASH;
          end
        end
      end
      ST_SQUASH: begin
        // Wrong-path bundles are consumed but never reach MEM.
        if (accept) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (trap_clear) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      res_q   <= 32'h0;
      sd_q    <= 32'h0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      f3_q    <= 3'd0;
      exc_q   <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      sd_q    <= sd_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      f3_q    <= f3_d;
      exc_q   <= exc_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = res_q;
  assign out_store_data = sd_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = rw_q;
  assign out_mem_read   = mr_q;
  assign out_mem_write  = mw_q;
  assign out_funct3     = f3_q;
  assign out_exc        = exc_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exmem_stage.sv
// Table-driven bench for exmem_stage with hand-written
// reset sequences around squash and trap states.
module tb_exmem_stage;

  localparam logic [1:0] K_ALU  = 2'd0;
  localparam logic [1:0] K_BR   = 2'd1;
  localparam logic [1:0] K_JAL  = 2'd2;
  localparam logic [1:0] K_JALR = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic        alu_flag;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        is_branch, is_jal, is_jalr;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic [2:0]  out_funct3;
  logic        out_exc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_clear;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          vld, ordy, tc;
    logic [1:0]  kind;
    bit          flag;
    logic [31:0] pc, imm, alu;
    logic [4:0]  rd;
    bit          mw;
    bit          e_rdy, e_ov;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    bit          e_rw, e_mw, e_exc, e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl[$];

  exmem_stage #(.WRONG_PATH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .alu_flag       (alu_flag),
    .pc             (pc),
    .imm            (imm),
    .is_branch      (is_branch),
    .is_jal         (is_jal),
    .is_jalr        (is_jalr),
    .rs2_data       (rs2_data),
    .rd             (rd),
    .reg_write      (reg_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_funct3     (mem_funct3),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_funct3     (out_funct3),
    .out_exc        (out_exc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_clear     (trap_clear)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    bit vld, bit ordy, bit tc, logic [1:0] kind, bit flag,
    logic [31:0] vpc, logic [31:0] vimm, logic [31:0] alu,
    logic [4:0] vrd, bit mw,
    bit e_rdy, bit e_ov, logic [31:0] e_res, logic [4:0] e_rd,
    bit e_rw, bit e_mw, bit e_exc, bit e_rv, logic [31:0] e_rpc
  );
    vec_t v;
    v.vld = vld; v.ordy = ordy; v.tc = tc; v.kind = kind;
    v.flag = flag; v.pc = vpc; v.imm = vimm; v.alu = alu;
    v.rd = vrd; v.mw = mw;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_res = e_res;
    v.e_rd = e_rd; v.e_rw = e_rw; v.e_mw = e_mw;
    v.e_exc = e_exc; v.e_rv = e_rv; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = v.vld;
    out_ready  = v.ordy;
    trap_clear = v.tc;
    is_branch  = (v.kind == K_BR);
    is_jal     = (v.kind == K_JAL);
    is_jalr    = (v.kind == K_JALR);
    alu_flag   = v.flag;
    pc         = v.pc;
    imm        = v.imm;
    alu_result = v.alu;
    rd         = v.rd;
    rs2_data   = 32'hA5A5_0000 | {27'd0, v.rd};
    reg_write  = (v.kind != K_BR);
    mem_read   = 1'b0;
    mem_write  = v.mw;
    mem_funct3 = 3'b010;
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, v.e_rdy});
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.e_ov});
    chk({tag, " redirect_valid"}, {31'd0, redirect_valid},
        {31'd0, v.e_rv});
    chk({tag, " redirect_pc"}, redirect_pc, v.e_rpc);
    if (v.e_ov) begin
      chk({tag, " out_result"}, out_result, v.e_res);
      chk({tag, " out_rd"}, {27'd0, out_rd}, {27'd0, v.e_rd});
      chk({tag, " out_store_data"}, out_store_data,
          32'hA5A5_0000 | {27'd0, v.e_rd});
      chk({tag, " out_reg_write"}, {31'd0, out_reg_write},
          {31'd0, v.e_rw});
      chk({tag, " out_mem_write"}, {31'd0, out_mem_write},
          {31'd0, v.e_mw});
      chk({tag, " out_exc"}, {31'd0, out_exc}, {31'd0, v.e_exc});
      chk({tag, " out_funct3"}, {29'd0, out_funct3}, 32'd2);
    end
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,1,0,K_ALU,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0);
    rst = 1'b1;
    drive(idle);

    // straight ALU, taken branch + squash, JAL, HALT, stalls
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h1234,5,0, 1,1,'h1234,5,1,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h55,6,1, 1,1,'h55,6,1,1,0,0,0));
    tbl.push_back(mk(1,1,0,K_BR,1,'h100,'h20,'h7,0,0, 1,1,'h7,0,0,0,0,1,'h120));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h11,7,0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_JAL,0,'h300,'h8,0,1,0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h33,8,0, 1,1,'h33,8,1,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_JAL,0,'h80,'h10,0,1,0, 1,1,'h84,1,1,0,0,1,'h90));
    tbl.push_back(mk(0,1,0,K_ALU,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h21,9,0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h22,9,0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_BR,0,'h200,'h40,'h1,0,0, 1,1,'h1,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_JALR,0,'h40,0,'h2003,2,1, 1,1,'h44,2,0,0,1,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h5,3,0, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h5,3,0, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,K_ALU,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,K_ALU,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h77,3,0, 1,1,'h77,3,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,K_ALU,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,K_ALU,0,0,0,'hABC,9,0, 1,1,'hABC,9,1,0,0,0,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,0,K_ALU,0,0,0,'hDEF,10,0, 0,1,'hABC,9,1,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'hDEF,10,0, 1,1,'hDEF,10,1,0,0,0,0));
    for (int k = 0; k < 2; k++)
      tbl.push_back(mk(1,0,0,K_JAL,0,'h400,'h20,0,1,0, 0,1,'hDEF,10,1,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_JAL,0,'h400,'h20,0,1,0, 1,1,'h404,1,1,0,0,1,'h420));
    tbl.push_back(mk(0,1,0,K_ALU,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,K_ALU,0,0,0,'h66,4,0, 1,0,0,0,0,0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset out_rd", {27'd0, out_rd}, 32'd0);
    chk("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);

    foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

    // reset mid-SQUASH (cnt=1), then a taken branch must redirect
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    #1;
    chk("rst squash out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst squash in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    apply("post-rst beq",
          mk(1,1,0,K_BR,1,'h500,'h8,'h3,0,0, 1,1,'h3,0,0,0,0,1,'h508));
    apply("post-rst idle",
          mk(0,1,0,K_ALU,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));

    // reset mid-HALT with a pending trapped bundle drops it
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply("jal misaligned",
          mk(1,0,0,K_JAL,0,'h600,'h6,0,1,0, 1,1,'h604,1,0,0,1,0,0));
    @(negedge clk);
    drive(idle);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst halt out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst halt out_exc", {31'd0, out_exc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply("post-halt alu",
          mk(1,1,0,K_ALU,0,0,0,'h42,4,0, 1,1,'h42,4,1,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
